// File: rtl/dram_resp_pkg.sv
// Shared definitions for the DRAM responder: access-size codes, FSM states,
// and small helpers for size and alignment decisions.
package dram_resp_pkg;

   // RISC-V funct3 load/store size codes
   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WAIT,
      WR
   } state_e;

   // Full-word access: the store needs no read-modify-write
   function automatic logic is_word(input logic [2:0] ctrl);
      return ctrl[1];
   endfunction

   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] a);
      if (ctrl[1])
         return (a != 2'b00);
      else if (ctrl[0])
         return a[0];
      else
         return 1'b0;
   endfunction

   // Byte offset of the access after aligning down to its own size
   function automatic logic [1:0] align_off(input logic [2:0] ctrl, input logic [1:0] a);
      if (ctrl[1])
         return 2'b00;
      else if (ctrl[0])
         return {a[1], 1'b0};
      else
         return a;
   endfunction

endpackage

// File: rtl/m_dram_lane.sv
// Combinational lane logic: extracts and extends the load lane from a read
// word, and merges the store lane into a read word for read-modify-write.
module m_dram_lane
   import dram_resp_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mdata
);

   logic [7:0]  b_lane;
   logic [15:0] h_lane;

   // Select the byte and half-word lanes addressed by the aligned offset
   always_comb begin
      b_lane = rdata[7:0];
      case (off)
         2'd0: b_lane = rdata[7:0];
         2'd1: b_lane = rdata[15:8];
         2'd2: b_lane = rdata[23:16];
         2'd3: b_lane = rdata[31:24];
         default: b_lane = rdata[7:0];
      endcase
      h_lane = off[1] ? rdata[31:16] : rdata[15:0];
   end

   // Load path: right-align the lane and sign- or zero-extend it
   always_comb begin
      ldata = rdata;
      case (ctrl)
         CTRL_B:  ldata = {{24{b_lane[7]}}, b_lane};
         CTRL_BU: ldata = {24'd0, b_lane};
         CTRL_H:  ldata = {{16{h_lane[15]}}, h_lane};
         CTRL_HU: ldata = {16'd0, h_lane};
         CTRL_W:  ldata = rdata;
         default: ldata = rdata;
      endcase
   end

   // Store path: overwrite only the addressed lane of the read word
   always_comb begin
      mdata = rdata;
      case (ctrl[1:0])
         2'b00: begin
            case (off)
               2'd0: mdata[7:0]   = wdata[7:0];
               2'd1: mdata[15:8]  = wdata[7:0];
               2'd2: mdata[23:16] = wdata[7:0];
               2'd3: mdata[31:24] = wdata[7:0];
               default: mdata = rdata;
            endcase
         end
         2'b01: begin
            if (off[1])
               mdata[31:16] = wdata[15:0];
            else
               mdata[15:0] = wdata[15:0];
         end
         default: mdata = wdata;
      endcase
   end

endmodule

// File: rtl/m_dram_responder.sv
// DRAM request responder: accepts one load or store at a time and executes
// it against a word-wide memory with variable read latency. Sub-word stores
// are performed as read-modify-write.
module m_dram_responder
   import dram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 24
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       w_dram_addr,
   input  logic [31:0]       w_dram_wdata,
   input  logic [2:0]        w_dram_ctrl,
   input  logic              w_dram_le,
   input  logic              w_dram_we_t,
   output logic              w_dram_busy,
   output logic [31:0]       w_dram_odata,
   output logic              w_misalign,
   output logic [ADDR_W-1:0] w_mem_addr,
   output logic [31:0]       w_mem_wdata,
   output logic              w_mem_re,
   output logic              w_mem_we,
   input  logic [31:0]       w_mem_rdata,
   input  logic              w_mem_rvalid
);

   state_e            state, state_nxt;
   logic              accept, rd_done;
   logic              req_store;
   logic [2:0]        req_ctrl;
   logic [1:0]        req_off;
   logic [31:0]       req_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       odata;
   logic              misalign;
   logic [31:0]       lane_ldata, lane_mdata;

   // Address bits above the memory window are not decoded
   if (ADDR_W < 30) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^w_dram_addr[31:ADDR_W+2];
   end

   m_dram_lane u_lane (
      .ctrl  (req_ctrl),
      .off   (req_off),
      .rdata (w_mem_rdata),
      .wdata (req_wdata),
      .ldata (lane_ldata),
      .mdata (lane_mdata)
   );

   // Next-state logic; a store strobe wins over a simultaneous load strobe
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (w_dram_we_t) begin
               accept    = 1'b1;
               state_nxt = is_word(w_dram_ctrl) ? WR : RD;
            end else if (w_dram_le) begin
               accept    = 1'b1;
               state_nxt = RD;
            end
         end
         RD:   state_nxt = WAIT;
         WAIT: begin
            if (w_mem_rvalid) begin
               rd_done   = 1'b1;
               state_nxt = req_store ? WR : IDLE;
            end
         end
         WR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Request latch, write-data merge and load-result register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_store <= 1'b0;
         req_ctrl  <= '0;
         req_off   <= '0;
         req_wdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         odata     <= '0;
         misalign  <= 1'b0;
      end else begin
         misalign <= 1'b0;
         if (accept) begin
            req_store <= w_dram_we_t;
            req_ctrl  <= w_dram_ctrl;
            req_off   <= align_off(w_dram_ctrl, w_dram_addr[1:0]);
            req_wdata <= w_dram_wdata;
            mem_addr  <= w_dram_addr[ADDR_W+1:2];
            misalign  <= is_misaligned(w_dram_ctrl, w_dram_addr[1:0]);
            if (w_dram_we_t && is_word(w_dram_ctrl))
               mem_wdata <= w_dram_wdata;
         end
         if (rd_done) begin
            if (req_store)
               mem_wdata <= lane_mdata;
            else
               odata <= lane_ldata;
         end
      end
   end

   assign w_dram_busy  = (state != IDLE);
   assign w_dram_odata = odata;
   assign w_misalign   = misalign;
   assign w_mem_addr   = mem_addr;
   assign w_mem_wdata  = mem_wdata;
   assign w_mem_re     = (state == RD);
   assign w_mem_we     = (state == WR);

endmodule

// File: tb/tb_m_dram_responder.sv
// Testbench for m_dram_responder: a latency-programmable memory, a byte-level
// reference model of memory contents and load results, directed cases and
// randomized load/store traffic.
module tb_m_dram_responder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] w_dram_addr = '0;
   logic [31:0] w_dram_wdata = '0;
   logic [2:0]  w_dram_ctrl = '0;
   logic        w_dram_le = 1'b0;
   logic        w_dram_we_t = 1'b0;
   logic        w_dram_busy;
   logic [31:0] w_dram_odata;
   logic        w_misalign;
   logic [23:0] w_mem_addr;
   logic [31:0] w_mem_wdata;
   logic        w_mem_re;
   logic        w_mem_we;
   logic [31:0] w_mem_rdata = '0;
   logic        w_mem_rvalid;

   int checks = 0;
   int errors = 0;

   logic [31:0] dram    [16];
   logic [31:0] ref_mem [16];
   logic [31:0] prev_od = '0;
   int          lat = 1;
   int          rd_cnt = 0;
   logic [31:0] rd_word = '0;
   logic        mem_rv = 1'b0;
   logic        stray_rv = 1'b0;

   assign w_mem_rvalid = mem_rv | stray_rv;

   m_dram_responder #(.ADDR_W(24)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .w_dram_addr  (w_dram_addr),
      .w_dram_wdata (w_dram_wdata),
      .w_dram_ctrl  (w_dram_ctrl),
      .w_dram_le    (w_dram_le),
      .w_dram_we_t  (w_dram_we_t),
      .w_dram_busy  (w_dram_busy),
      .w_dram_odata (w_dram_odata),
      .w_misalign   (w_misalign),
      .w_mem_addr   (w_mem_addr),
      .w_mem_wdata  (w_mem_wdata),
      .w_mem_re     (w_mem_re),
      .w_mem_we     (w_mem_we),
      .w_mem_rdata  (w_mem_rdata),
      .w_mem_rvalid (w_mem_rvalid)
   );

   always #5 CLK = ~CLK;

   // Memory: writes land when we is seen; read data returns lat cycles after re
   always @(negedge CLK) begin
      if (w_mem_we) dram[w_mem_addr[3:0]] = w_mem_wdata;
      mem_rv = 1'b0;
      if (rd_cnt != 0) begin
         rd_cnt = rd_cnt - 1;
         if (rd_cnt == 0) begin
            mem_rv      = 1'b1;
            w_mem_rdata = rd_word;
         end
      end
      if (w_mem_re) begin
         rd_cnt  = lat;
         rd_word = dram[w_mem_addr[3:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"},  32'(w_dram_busy),  32'd0);
      chk({tag, "_odata"}, w_dram_odata,      32'd0);
      chk({tag, "_mis"},   32'(w_misalign),   32'd0);
      chk({tag, "_maddr"}, 32'(w_mem_addr),   32'd0);
      chk({tag, "_mwdat"}, w_mem_wdata,       32'd0);
      chk({tag, "_re"},    32'(w_mem_re),     32'd0);
      chk({tag, "_we"},    32'(w_mem_we),     32'd0);
   endtask

   // One request, checked against the reference model and the timing rules
   task automatic run_op(input bit st, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, input int l, input bit both, input bit spam);
      int          idx, sz, off, exp_done, exp_re, exp_we, exp_we_cyc, exp_mis;
      int          done, re_cnt, re_cyc, we_cnt, we_cyc, mis_cnt, mis_cyc, bad_addr;
      logic [31:0] al, old, v, mask, newv, exp_od, exp_wa, we_dat;
      lat  = l;
      idx  = int'(addr[5:2]);
      sz   = ctrl[1] ? 4 : (ctrl[0] ? 2 : 1);
      al   = addr & ~(32'(sz) - 32'd1);
      off  = int'(al[1:0]);
      exp_wa  = (addr >> 2) & 32'h00FF_FFFF;
      exp_mis = (al != addr) ? 1 : 0;
      old  = ref_mem[idx];
      v    = old >> (8 * off);
      if (sz == 1) begin
         v = v & 32'hFF;
         if (ctrl[2] == 1'b0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = v & 32'hFFFF;
         if (ctrl[2] == 1'b0 && v[15]) v = v | 32'hFFFF_0000;
      end
      if (sz == 4) newv = wd;
      else begin
         mask = ((32'd1 << (8 * sz)) - 32'd1) << (8 * off);
         newv = (old & ~mask) | ((wd << (8 * off)) & mask);
      end
      if (!st) begin
         exp_re = 1; exp_we = 0; exp_we_cyc = 0; exp_done = 2 + l; exp_od = v;
      end else if (sz == 4) begin
         exp_re = 0; exp_we = 1; exp_we_cyc = 1; exp_done = 2; exp_od = prev_od;
      end else begin
         exp_re = 1; exp_we = 1; exp_we_cyc = 2 + l; exp_done = 3 + l; exp_od = prev_od;
      end

      @(negedge CLK);
      w_dram_addr  = addr;
      w_dram_wdata = wd;
      w_dram_ctrl  = ctrl;
      w_dram_le    = !st || both;
      w_dram_we_t  = st;
      done = 0; re_cnt = 0; re_cyc = 0; we_cnt = 0; we_cyc = 0;
      mis_cnt = 0; mis_cyc = 0; bad_addr = 0; we_dat = '0;
      for (int k = 1; k <= 40 && done == 0; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            w_dram_le   = spam;
            w_dram_we_t = spam;
            if (spam) begin
               w_dram_addr  = 32'h8000_0000 | 32'($urandom_range(0, 63));
               w_dram_wdata = $urandom;
            end
         end else begin
            w_dram_le   = 1'b0;
            w_dram_we_t = 1'b0;
         end
         if (w_mem_re) begin
            re_cnt++; re_cyc = k;
            if (32'(w_mem_addr) != exp_wa) bad_addr++;
         end
         if (w_mem_we) begin
            we_cnt++; we_cyc = k; we_dat = w_mem_wdata;
            if (32'(w_mem_addr) != exp_wa) bad_addr++;
         end
         if (w_misalign) begin
            mis_cnt++; mis_cyc = k;
         end
         if (!w_dram_busy) done = k;
      end
      w_dram_le   = 1'b0;
      w_dram_we_t = 1'b0;
      chk("busy_low_cycle", 32'(done),     32'(exp_done));
      chk("re_count",       32'(re_cnt),   32'(exp_re));
      chk("re_cycle",       32'(re_cyc),   32'(exp_re));
      chk("we_count",       32'(we_cnt),   32'(exp_we));
      chk("we_cycle",       32'(we_cyc),   32'(exp_we_cyc));
      chk("we_data",        we_dat,        st ? newv : 32'd0);
      chk("misalign_count", 32'(mis_cnt),  32'(exp_mis));
      chk("misalign_cycle", 32'(mis_cyc),  32'(exp_mis));
      chk("mem_addr",       32'(bad_addr), 32'd0);
      chk("odata",          w_dram_odata,  exp_od);
      if (spam) begin
         @(negedge CLK);
         chk("spam_ignored_busy", 32'(w_dram_busy), 32'd0);
      end
      if (st) ref_mem[idx] = newv;
      else    prev_od = v;
   endtask

   initial begin
      logic [31:0] r;
      logic [2:0]  lctl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      bit          st;
      logic [2:0]  c;
      int          late_we, late_busy;

      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         dram[i] = r;
         ref_mem[i] = r;
      end

      // Reset state, plus stray read-valid right after reset
      @(negedge CLK);
      @(negedge CLK);
      chk_outputs_zero("reset");
      RST = 1'b0;
      stray_rv = 1'b1;
      @(negedge CLK);
      stray_rv = 1'b0;
      @(negedge CLK);
      chk("stray_rvalid_busy",  32'(w_dram_busy), 32'd0);
      chk("stray_rvalid_odata", w_dram_odata,     32'd0);

      // Sign/zero-extended loads from a known word
      dram[4] = 32'h80FF_7F01; ref_mem[4] = 32'h80FF_7F01;
      run_op(1'b0, 3'b000, 32'h8000_0012, 32'd0, 1, 1'b0, 1'b0);
      run_op(1'b0, 3'b100, 32'h8000_0012, 32'd0, 1, 1'b0, 1'b0);
      run_op(1'b0, 3'b001, 32'h8000_0012, 32'd0, 1, 1'b0, 1'b0);
      run_op(1'b0, 3'b101, 32'h8000_0010, 32'd0, 2, 1'b0, 1'b0);

      // Sub-word read-modify-write stores
      dram[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
      run_op(1'b1, 3'b000, 32'h8000_0011, 32'h0000_00AB, 1, 1'b0, 1'b0);
      dram[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
      run_op(1'b1, 3'b001, 32'h8000_0012, 32'h0000_BEEF, 1, 1'b0, 1'b0);

      // Word store and readback
      run_op(1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
      run_op(1'b0, 3'b010, 32'h8000_0020, 32'd0, 1, 1'b0, 1'b0);

      // Misaligned requests execute at the aligned-down address
      run_op(1'b0, 3'b010, 32'h8000_0013, 32'd0, 1, 1'b0, 1'b0);
      run_op(1'b0, 3'b001, 32'h8000_0011, 32'd0, 1, 1'b0, 1'b0);
      run_op(1'b1, 3'b010, 32'h8000_0016, 32'hCAFE_F00D, 2, 1'b0, 1'b0);

      // Both strobes high, strobes while busy, long latency
      run_op(1'b1, 3'b000, 32'h8000_0030, 32'h0000_005A, 1, 1'b1, 1'b0);
      run_op(1'b0, 3'b000, 32'h8000_0031, 32'd0, 3, 1'b0, 1'b1);
      run_op(1'b1, 3'b001, 32'h8000_0036, 32'h0000_1234, 2, 1'b0, 1'b1);
      run_op(1'b0, 3'b010, 32'h8000_0008, 32'd0, 5, 1'b0, 1'b0);

      // Reset while waiting for read data; late data must be ignored
      lat = 5;
      @(negedge CLK);
      w_dram_addr = 32'h8000_0020; w_dram_ctrl = 3'b010; w_dram_le = 1'b1;
      @(negedge CLK);
      w_dram_le = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #1 RST = 1'b1;
      #1 chk_outputs_zero("reset_in_wait");
      @(negedge CLK);
      RST = 1'b0;
      prev_od = '0;
      late_we = 0; late_busy = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (w_mem_we) late_we++;
         if (w_dram_busy) late_busy++;
      end
      chk("after_reset_we",   32'(late_we),   32'd0);
      chk("after_reset_busy", 32'(late_busy), 32'd0);
      chk("after_reset_odata", w_dram_odata,  32'd0);
      run_op(1'b0, 3'b010, 32'h8000_0020, 32'd0, 1, 1'b0, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom_range(0, 1));
         c  = st ? 3'($urandom_range(0, 2)) : lctl[$urandom_range(0, 4)];
         run_op(st, c, 32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom,
                $urandom_range(1, 4), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 5) == 0));
      end

      @(negedge CLK);
      @(negedge CLK);
      for (int i = 0; i < 16; i++) chk("mem_final", dram[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_dram_responder.md
# m_dram_responder

Memory-side responder for the core's DRAM request port (addr / wdata / odata / we_t / le / ctrl / busy). It accepts one load or store at a time from a hart's MMU and executes it against a word-wide synchronous memory with variable read latency. It does byte and half-word loads with sign/zero extension, and performs sub-word stores as read-modify-write. It sits between the per-hart bus master and the DRAM model or controller.

## Interface
Parameters:
- ADDR_W, 24, word-address width toward memory (byte address bits [ADDR_W+1:2] used)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- w_dram_addr  in  32  byte address of request
- w_dram_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- w_dram_ctrl  in  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- w_dram_le  in  1  load request strobe, one cycle
- w_dram_we_t  in  1  store request strobe, one cycle
- w_dram_busy  out  1  request in progress
- w_dram_odata  out  32  load result, extended and right-aligned
- w_misalign  out  1  one-cycle pulse: accepted request was misaligned
- w_mem_addr  out  ADDR_W  word address
- w_mem_wdata  out  32  full word to write
- w_mem_re  out  1  read strobe, one cycle
- w_mem_we  out  1  write strobe, one cycle
- w_mem_rdata  in  32  read data
- w_mem_rvalid  in  1  read data valid, ≥1 cycle after w_mem_re

## Operation
- States: IDLE, RD, WAIT, WR.
- A request is accepted only in IDLE. Strobes arriving while busy are ignored; the requester must not issue them.
- If le and we_t are both high, the store wins and the load is dropped.
- On accept, latch addr, wdata and ctrl.
- Misaligned requests:
  - Condition: half-word with addr[0]=1, or word with addr[1:0]≠0.
  - The request is executed at the address aligned down to its size.
  - w_misalign pulses in the cycle after accept.
- Load: IDLE → RD (w_mem_re=1) → WAIT until w_mem_rvalid.
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for B/H, zero-extend for BU/HU/W.
  - Register into w_dram_odata, then → IDLE.
- Word store: IDLE → WR (w_mem_we=1, w_mem_wdata=wdata) → IDLE.
- Sub-word store: IDLE → RD → WAIT, then merge the wdata lane into the read word → WR → IDLE.
- w_mem_rvalid outside WAIT is ignored (covers stray data after reset).
- w_dram_odata holds its value until the next load completes; stores do not change it.
- w_dram_busy is high in every state except IDLE (registered, no combinational path from strobes).
- w_mem_addr and w_mem_wdata are held stable from RD/WR entry until the return to IDLE.

## Timing
- Reset (async, any state): state IDLE. Every output is 0: w_dram_busy, w_dram_odata, w_misalign, w_mem_addr, w_mem_wdata, w_mem_re, w_mem_we.
- Request strobe in cycle T; read latency L (rvalid in cycle T+1+L, L≥1).
- Load: busy high T+1..T+1+L, w_mem_re high in T+1 only. odata valid and busy low in T+2+L.
- Word store: w_mem_we and busy high in T+1; busy low in T+2.
- Sub-word store: w_mem_re in T+1, w_mem_we in T+2+L, busy low in T+3+L.
- Back-to-back: the next request may be strobed in the first cycle busy is low.
- Reset mid-operation aborts it. No w_mem_we is issued after reset deasserts until a new store is accepted.

## Structure
- Shared package dram_resp_pkg:
  - ctrl size codes (B, H, W, BU, HU)
  - state enum (IDLE, RD, WAIT, WR)
  - function is_misaligned(ctrl, addr[1:0])
- One combinational sub-module, m_dram_lane, handles both lane extraction with sign/zero extension (load path) and lane merge (store path). The FSM and registers stay in m_dram_responder.

## Test plan
- Memory word 0x8000_0010 = 0x80FF_7F01, L=1. LB @0x8000_0012 → odata 0xFFFF_FFFF, busy low T+3. LBU same → 0x0000_00FF. LH @0x8000_0012 → 0xFFFF_80FF.
- SB 0xAB @0x8000_0011 onto word 0x1122_3344 → w_mem_wdata 0x1122_AB44 with w_mem_we at T+3; SH 0xBEEF @+2 → 0xBEEF_3344.
- SW 0xDEAD_BEEF @0x8000_0020 → w_mem_we only in T+1, no w_mem_re, busy low T+2; readback LW returns 0xDEAD_BEEF.
- LW @0x8000_0013 → w_misalign pulse at T+1, read of word 0x8000_0010; LH @...11 → aligned to ...10.
- le and we_t both high → store performed, odata unchanged. Strobes during busy ignored. L=5 load → busy low at T+7.
- RST asserted in WAIT → all outputs 0 immediately. Late rvalid ignored. Next LW completes correctly.
